// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : des_key_schedule
// Brief    : Sequential DES subkey generator fed by PC-1; one PC-2 subkey per round.
// Revision : 1.0 - initial release
// ============================================================================
module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [27:0] c_in,
    input  logic [27:0] d_in,
    input  logic        hold,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic [3:0]  round_num,
    output logic        busy,
    output logic        done
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // PC-2 source positions, already converted to 0-based indices into {D, C}.
    localparam logic [5:0] c_PC2 [48] = '{
        6'd13, 6'd16, 6'd10, 6'd23, 6'd0,  6'd4,  6'd2,  6'd27,
        6'd14, 6'd5,  6'd20, 6'd9,  6'd22, 6'd18, 6'd11, 6'd3,
        6'd25, 6'd7,  6'd15, 6'd6,  6'd26, 6'd19, 6'd12, 6'd1,
        6'd40, 6'd51, 6'd30, 6'd36, 6'd46, 6'd54, 6'd29, 6'd39,
        6'd50, 6'd44, 6'd32, 6'd47, 6'd43, 6'd48, 6'd38, 6'd55,
        6'd33, 6'd52, 6'd45, 6'd41, 6'd49, 6'd35, 6'd28, 6'd31
    };

    // Bit (r-1) set when DES round r uses a two-position rotation.
    localparam logic [15:0] c_SHIFT_TWO = 16'b0111_1110_1111_1100;

    state_t      state_q;
    logic [27:0] c_q;
    logic [27:0] d_q;
    logic [3:0]  round_q;
    logic        mode_q;
    logic        valid_q;
    logic        done_q;

    logic [55:0] w_cd;
    logic [3:0]  w_shift_idx;
    logic        w_shift_two;
    logic [27:0] c_step_d;
    logic [27:0] d_step_d;

    function automatic logic [27:0] rot_left(input logic [27:0] v, input logic two);
        return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

    function automatic logic [27:0] rot_right(input logic [27:0] v, input logic two);
        return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    // Encrypt advances into round round_q+2; decrypt walks the table backwards.
    assign w_shift_idx = mode_q ? ~round_q : (round_q + 4'd1);
    assign w_shift_two = c_SHIFT_TWO[w_shift_idx];
    assign c_step_d    = mode_q ? rot_right(c_q, w_shift_two) : rot_left(c_q, w_shift_two);
    assign d_step_d    = mode_q ? rot_right(d_q, w_shift_two) : rot_left(d_q, w_shift_two);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            c_q     <= 28'd0;
            d_q     <= 28'd0;
            round_q <= 4'd0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_ACTIVE;
                        // Decrypt starts from C16/D16, which equal C0/D0.
                        c_q     <= decrypt ? c_in : rot_left(c_in, 1'b0);
                        d_q     <= decrypt ? d_in : rot_left(d_in, 1'b0);
                        round_q <= 4'd0;
                        mode_q  <= decrypt;
                        valid_q <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (!hold) begin
                        if (round_q == 4'd15) begin
                            state_q <= ST_IDLE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            c_q     <= c_step_d;
                            d_q     <= d_step_d;
                            round_q <= round_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign w_cd = {d_q, c_q};

    for (genvar j = 0; j < 48; j++) begin : g_pc2
        assign subkey[j] = w_cd[c_PC2[j]];
    end

    assign subkey_valid = valid_q;
    assign busy         = valid_q;
    assign round_num    = round_q;
    assign done         = done_q;

endmodule
`default_nettype wire

// File: doc/des_key_schedule.md
# des_key_schedule

Sequential DES key-schedule generator, directly downstream of PC-1. It loads the 28-bit C and D halves that PC-1 produces and walks them through the 16 round rotations, left for encryption and right for decryption. Each round it applies PC-2 and presents one 48-bit subkey with a valid flag to the round datapath. A hold input stalls the sequence.

## Interface
Parameters: none (DES-fixed).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begin a schedule; sampled only in IDLE.
- decrypt  input  1  0 = encrypt order K1..K16, 1 = decrypt order K16..K1; sampled with start.
- c_in  input  28  C0 from PC-1; bit 0 = DES C bit 1.
- d_in  input  28  D0 from PC-1; bit 0 = DES D bit 1.
- hold  input  1  stall; freezes the state in ACTIVE.
- subkey  output  48  PC-2 of current C/D; bit 0 = DES subkey bit 1.
- subkey_valid  output  1  subkey is valid for round round_num.
- round_num  output  4  0..15; the datapath round index.
- busy  output  1  high in ACTIVE.
- done  output  1  one-cycle pulse after the last subkey is consumed.

## Operation
- States are IDLE and ACTIVE. Registers are C[27:0], D[27:0], round_num[3:0], mode, valid and done.
- Rotation convention: left rotate by s gives new[i] = old[(i+s) mod 28]. Right rotate by s gives new[i] = old[(i-s) mod 28].
- Shift schedule for rounds 1..16 is s = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Encrypt:
  - On start, C = ROTL(c_in, 1) and D = ROTL(d_in, 1); this is round 1.
  - Each advance to datapath round r (1-based) rotates C and D left by s_r.
- Decrypt:
  - On start, C = c_in and D = d_in, unrotated, since C16 = C0.
  - Each advance to datapath round r ≥ 2 rotates C and D right by s_(18-r). Round 2 uses s16 = 1; round 16 uses s2 = 1.
- PC-2 mapping: subkey[j] = CD[P[j]-1], where CD[0..27] = C and CD[28..55] = D.
- P = 14 17 11 24 1 5 3 28 15 6 21 10 23 19 12 4 26 8 16 7 27 20 13 2 41 52 31 37 47 55 30 40 51 45 33 48 44 49 39 56 34 53 46 42 50 36 29 32.
- subkey is combinational from the C/D registers, so it is aligned with subkey_valid.
- IDLE → ACTIVE: on start=1. Loads C and D as above, round_num = 0, valid = 1, mode = decrypt.
- ACTIVE with hold=1: every register holds its value; the subkey stays stable.
- ACTIVE with hold=0 and round_num < 15: advance once (rotate, then round_num + 1).
- ACTIVE with hold=0 and round_num = 15: valid → 0, done → 1 for one cycle, return to IDLE. C, D and round_num retain their values.
- start is ignored while ACTIVE, including in the final cycle; a restart is accepted no earlier than the cycle done is high.
- In IDLE, hold has no effect. start together with hold is accepted, and hold takes effect from the first ACTIVE cycle.
- Reset (rst_n = 0 on a clock edge, in any state including mid-schedule):
  - The state returns to IDLE.
  - C, D, round_num, valid and done are cleared to 0.
  - subkey therefore reads 0.

## Timing
- Reset values: subkey = 0, subkey_valid = 0, round_num = 0, busy = 0, done = 0.
- Latency: start high at edge N gives the first subkey valid in cycle N+1.
- With no hold, subkeys for round_num 0..15 appear in cycles N+1..N+16. valid falls and done pulses in cycle N+17.
- Each held cycle extends the schedule by exactly one cycle.
- The datapath consumes subkey in any cycle where subkey_valid = 1 and hold = 0.
- busy equals subkey_valid. busy is low in the done cycle, so back-to-back schedules have a 1-cycle gap.
- There is no combinational path from inputs to outputs. subkey depends only on registers.

## Test plan
All values below are written DES bit 1 first (bit 1 = index 0 = MSB of the hex string).
- Reset: hold rst_n = 0 for 2 cycles mid-schedule → all outputs are 0 on the next cycle, and the FSM is IDLE.
- Encrypt, key 133457799BBCDFF1 (C0 = F0CCAAF, D0 = 556678F), start with decrypt = 0:
  - Cycle N+1: subkey = 1B02EFFC7072, round_num = 0.
  - Cycle N+16: subkey = CB3D8B0E17F5, round_num = 15.
  - Cycle N+17: done = 1, valid = 0.
- Decrypt, same key, decrypt = 1 → cycle N+1 gives CB3D8B0E17F5; cycle N+16 gives 1B02EFFC7072. All 16 subkeys equal the encrypt sequence reversed.
- Hold: assert hold for 3 cycles at round_num = 7 → subkey and round_num are frozen for those cycles, and done arrives 3 cycles late. Hold asserted at round_num = 15 delays done.
- start while busy: pulse start at round_num = 5 with different c_in → no effect. The sequence completes unchanged, and a new start in the done cycle is accepted.
- Reset mid-operation: pull rst_n low at round_num = 9 → IDLE and zeroed outputs. A subsequent start produces the full correct 16-subkey sequence.
